// File: rtl/prog_loader.sv
// Streams instruction words into the add-jump processor's assembler port,
// pads the unused program slots with NOPs, then runs a paced number of steps.
module prog_loader #(
    parameter int SLOTS    = 16,
    parameter int STEP_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               run_steps,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [21:0]              s_word,
    input  logic                     s_last,
    output logic [15:0]              value,
    output logic [1:0]               dest,
    output logic [1:0]               src,
    output logic                     add,
    output logic                     jump,
    output logic                     prog,
    output logic                     advance,
    output logic [$clog2(SLOTS)-1:0] slot,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf
);
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int CNT_W  = $clog2(STEP_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_DIV - 2);

    typedef enum logic [3:0] {
        S_IDLE, S_L_WAIT, S_L_SETUP, S_L_PULSE, S_L_HOLD,
        S_P_SETUP, S_P_PULSE, S_P_HOLD, S_R_WAIT, S_R_PULSE, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    state_t              w_run_entry;
    logic [SLOT_W-1:0]   r_slot;
    logic [7:0]          r_steps;
    logic [21:0]         r_word;
    logic                r_last;
    logic                r_ovf;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_wrap;
    logic                w_cnt_end;

    // The slot about to be written last means its increment wraps the PC to 0.
    assign w_wrap      = (r_slot == SLOT_LAST);
    assign w_cnt_end   = (r_cnt == CNT_LAST);
    assign w_run_entry = (r_steps == 8'd0) ? S_DONE : S_R_WAIT;
    assign slot        = r_slot;
    assign ovf         = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        prog         = 1'b0;
        advance      = 1'b0;
        value        = '0;
        dest         = '0;
        src          = '0;
        add          = 1'b0;
        jump         = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                done = (r_state == S_DONE);
                if (start) w_state_next = S_L_WAIT;
            end
            S_L_WAIT: begin
                s_ready = 1'b1;
                prog    = 1'b1;
                if (s_valid) w_state_next = S_L_SETUP;
            end
            S_L_SETUP, S_L_PULSE, S_L_HOLD: begin
                prog = 1'b1;
                {add, jump, dest, src, value} = r_word;
                if (r_state == S_L_SETUP) begin
                    w_state_next = S_L_PULSE;
                end else if (r_state == S_L_PULSE) begin
                    advance      = 1'b1;
                    w_state_next = S_L_HOLD;
                end else if (w_wrap) begin
                    w_state_next = w_run_entry;
                end else if (r_last) begin
                    w_state_next = S_P_SETUP;
                end else begin
                    w_state_next = S_L_WAIT;
                end
            end
            S_P_SETUP: begin
                prog         = 1'b1;
                w_state_next = S_P_PULSE;
            end
            S_P_PULSE: begin
                prog         = 1'b1;
                advance      = 1'b1;
                w_state_next = S_P_HOLD;
            end
            S_P_HOLD: begin
                prog         = 1'b1;
                w_state_next = w_wrap ? w_run_entry : S_P_SETUP;
            end
            S_R_WAIT: begin
                if (r_steps == 8'd0) w_state_next = S_DONE;
                else if (w_cnt_end)  w_state_next = S_R_PULSE;
            end
            S_R_PULSE: begin
                advance      = 1'b1;
                w_state_next = (r_steps == 8'd1) ? S_DONE : S_R_WAIT;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot  <= '0;
            r_steps <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_steps <= run_steps;
                        r_ovf   <= 1'b0;
                        r_slot  <= '0;
                    end
                end
                S_L_WAIT: begin
                    if (s_valid) begin
                        r_word <= s_word;
                        r_last <= s_last;
                    end
                end
                S_L_HOLD, S_P_HOLD: begin
                    r_slot <= r_slot + 1'b1;
                    r_cnt  <= '0;
                    if ((r_state == S_L_HOLD) && w_wrap && !r_last) r_ovf <= 1'b1;
                end
                S_R_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_R_PULSE: begin
                    r_steps <= r_steps - 8'd1;
                    r_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Randomised load/pad/run sequences for prog_loader, checked against an
// expected strobe list derived from the word list, s_last position and step count.
module tb_prog_loader;
    localparam int STEP_DIV = 4;
    localparam int SLOTS    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  run_steps = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [21:0] s_word = '0;
    logic        s_last = 1'b0;
    logic [15:0] value;
    logic [1:0]  dest;
    logic [1:0]  src;
    logic        add;
    logic        jump;
    logic        prog;
    logic        advance;
    logic [3:0]  slot;
    logic        busy;
    logic        done;
    logic        ovf;

    prog_loader #(.SLOTS(SLOTS), .STEP_DIV(STEP_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .run_steps(run_steps),
        .s_valid(s_valid), .s_ready(s_ready), .s_word(s_word), .s_last(s_last),
        .value(value), .dest(dest), .src(src), .add(add), .jump(jump),
        .prog(prog), .advance(advance), .slot(slot), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic        prog;
        logic [21:0] f;
        logic [3:0]  slot;
    } strobe_t;

    strobe_t sq[$];
    int      xq[$];

    // Log every handshake and every advance strobe, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) xq.push_back(cyc);
            if (advance) sq.push_back('{cyc, prog, {add, jump, dest, src, value}, slot});
        end
    end

    // L >= 0: index of the word carrying s_last; L < 0: no s_last (overflow case).
    task automatic run_seq(input int L, input int steps, input bit gaps, input bit poke, input bit fixed);
        logic [21:0] w[16];
        int acc, pads, n, j;
        logic exp_ovf;
        acc     = (L >= 0) ? L + 1 : 16;
        pads    = (L >= 0) ? 16 - acc : 0;
        exp_ovf = (L < 0);
        for (int i = 0; i < 16; i++) w[i] = 22'($urandom);
        if (fixed) w[0] = {1'b1, 1'b0, 2'd1, 2'd0, 16'h00A5};
        xq.delete();
        sq.delete();
        @(posedge clk); #1;
        start = 1'b1; run_steps = 8'(steps);
        @(posedge clk); #1;
        start = 1'b0; run_steps = 8'($urandom);
        for (int i = 0; i < acc; i++) begin
            s_valid = 1'b1; s_word = w[i]; s_last = (i == L);
            n = 0;
            while (1) begin
                @(negedge clk);
                if (s_ready || n > 200) break;
                n++;
            end
            if (n > 200) check("ready_timeout", 32'(s_ready), 32'd1);
            @(posedge clk); #1;
            s_valid = 1'b0; s_last = 1'b0;
            if (poke && i == 0) begin
                start = 1'b1; run_steps = 8'(steps + 3);
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        if (L < 0) begin
            s_valid = 1'b1; s_word = 22'($urandom); s_last = 1'b1;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 3000);
        check("done_reached", 32'(done), 32'd1);
        s_valid = 1'b0; s_last = 1'b0;
        check("n_xfer", 32'(xq.size()), 32'(acc));
        check("n_strobe", 32'(sq.size()), 32'(acc + pads + steps));
        check("ovf", 32'(ovf), 32'(exp_ovf));
        check("slot_end", 32'(slot), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("ready_end", 32'(s_ready), 32'd0);
        if (xq.size() == acc && sq.size() == acc + pads + steps) begin
            for (int i = 0; i < acc; i++) begin
                check("ld_fields", 32'(sq[i].f), 32'(w[i]));
                check("ld_latency", 32'(sq[i].cyc - xq[i]), 32'd2);
                check("ld_prog", 32'(sq[i].prog), 32'd1);
                check("ld_slot", 32'(sq[i].slot), 32'(i));
                if (i > 0 && !gaps && !poke) check("b2b_gap", 32'(xq[i] - xq[i-1]), 32'd4);
            end
            for (int k = 0; k < pads; k++) begin
                j = acc + k;
                check("pad_fields", 32'(sq[j].f), 32'd0);
                check("pad_prog", 32'(sq[j].prog), 32'd1);
                check("pad_slot", 32'(sq[j].slot), 32'(j));
            end
            for (int k = 0; k < steps; k++) begin
                j = acc + pads + k;
                check("run_prog", 32'(sq[j].prog), 32'd0);
                check("run_fields", 32'(sq[j].f), 32'd0);
                if (k > 0) check("run_period", 32'(sq[j].cyc - sq[j-1].cyc), 32'(STEP_DIV));
            end
        end
        $display("seq last_idx=%0d steps=%0d gaps=%0d poke=%0d xfers=%0d strobes=%0d ovf=%0d",
                 L, steps, gaps, poke, xq.size(), sq.size(), ovf);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom); s_valid = 1'($urandom); s_word = 22'($urandom);
            s_last = 1'($urandom); run_steps = 8'($urandom);
            @(negedge clk);
            check("reset_outputs",
                  {s_ready, value, dest, src, add, jump, prog, advance, slot, busy, done, ovf}, 32'd0);
        end
        start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_ready", 32'(s_ready), 32'd0);

        run_seq(2, 5, 1'b0, 1'b0, 1'b1);
        run_seq(-1, int'($urandom_range(1, 4)), 1'b0, 1'b0, 1'b0);
        run_seq(4, 0, 1'b0, 1'b0, 1'b0);
        run_seq(15, 2, 1'b0, 1'b0, 1'b0);
        run_seq(5, 3, 1'b1, 1'b1, 1'b0);
        for (int t = 0; t < 6; t++)
            run_seq(int'($urandom_range(0, 16)) - 1, int'($urandom_range(0, 6)),
                    1'($urandom), 1'($urandom), 1'b0);

        // Reset while an advance strobe is high must drop it within the cycle.
        @(posedge clk); #1;
        start = 1'b1; run_steps = 8'd3;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_word = 22'($urandom); s_last = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!advance && n < 50);
        check("pulse_seen", 32'(advance), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_advance", 32'(advance), 32'd0);
        check("async_rst_prog", 32'(prog), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        s_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        $display("seq async reset during load pulse");

        run_seq(0, 2, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream stage for the add-jump processor top level.
- Accepts a stream of instruction words over a valid/ready handshake and sequences them into the processor's assembler interface: drives `value`, `dest`, `src`, `add`, `jump` and `prog`, and generates `advance` strobes.
- After loading, it pads the unused program slots with NOPs so the processor PC wraps back to 0.
- It then releases `prog` and issues a programmed number of paced `advance` strobes to run the program.

Parameters:
- SLOTS, 16, program memory depth; must equal 2^(processor PC width).
- STEP_DIV, 4, clk cycles per `advance` period in run mode; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a load+run sequence; sampled in IDLE or DONE only.
- run_steps  in  8  number of run-mode `advance` strobes; sampled when start is accepted.
- s_valid  in  1  instruction word valid.
- s_ready  out  1  loader can accept a word.
- s_word  in  22  {add, jump, dest[1:0], src[1:0], value[15:0]}, MSB first.
- s_last  in  1  qualifies s_word as the final instruction.
- value  out  16  to processor value.
- dest  out  2  to processor dest.
- src  out  2  to processor src.
- add  out  1  to processor add.
- jump  out  1  to processor jump.
- prog  out  1  to processor prog; 1 during load/pad.
- advance  out  1  to processor advance; single-cycle high strobe.
- slot  out  4  slot index being written (mirrors processor PC during load).
- busy  out  1  high in every state except IDLE/DONE.
- done  out  1  high in DONE.
- ovf  out  1  sticky: 16 words accepted without s_last; cleared on start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, including s_ready, prog, advance and slot. Internal counters cleared.
- Precondition: the processor PC is 0 when start is accepted. The loader guarantees PC=0 at load end.
- States: IDLE, L_WAIT, L_SETUP, L_PULSE, L_HOLD, P_SETUP, P_PULSE, P_HOLD, R_WAIT, R_PULSE, DONE.
- IDLE/DONE: on start=1, latch run_steps, clear ovf, set slot=0, go to L_WAIT. done is high only in DONE.
- L_WAIT: s_ready=1, prog=1. A transfer occurs when s_valid & s_ready; capture s_word and s_last, then go to L_SETUP.
- Load timing, transfer at edge T:
  - fields and prog=1 valid from T+1 (L_SETUP);
  - advance=1 for exactly cycle T+2 (L_PULSE);
  - fields held through T+3 (L_HOLD);
  - throughput is 1 word per 4 cycles.
  - Fields stay stable from SETUP through HOLD inclusive.
- End of L_HOLD: slot increments by 1, modulo 16. Then, in priority order:
  - slot wrapped to 0: if the captured s_last=0, set ovf=1; go to R_WAIT.
  - else if captured s_last=1: go to P_SETUP.
  - else: go to L_WAIT.
- Pad (P_SETUP/P_PULSE/P_HOLD): same 3-cycle timing with value/dest/src/add/jump=0 and prog=1. Repeat until slot wraps to 0, then go to R_WAIT. s_ready=0 throughout.
- Run:
  - prog=0 and fields=0 throughout.
  - If the latched run_steps=0, go directly to DONE.
  - R_WAIT holds for STEP_DIV-1 cycles, then R_PULSE asserts advance=1 for 1 cycle and decrements the remaining-step count. Strobes are therefore exactly STEP_DIV cycles apart.
  - After the last strobe, go to DONE.
- s_ready is 0 in all states except L_WAIT. Words presented elsewhere are not consumed.
- start is ignored while busy=1.
- advance is never high in two consecutive cycles.
- Reset mid-operation aborts immediately; the processor program state is undefined afterwards.

Test Plan:
- Reset: hold rst_n=0 with inputs toggling -> all outputs 0. Release rst_n -> IDLE, busy=0, done=0.
- Load 3 words with s_last on word 3, e.g. word1={1,0,2'd1,2'd0,16'h00A5}:
  - each word -> one advance strobe 2 cycles after its transfer, with prog=1 and matching fields;
  - then 13 pad strobes with zero fields;
  - slot returns to 0, ovf=0.
- Back-to-back s_valid=1: successive transfers are exactly 4 cycles apart; s_ready is low for 3 cycles after each transfer.
- 16 words, none with s_last:
  - 16 load strobes, ovf=1, no pad strobes;
  - 17th word not accepted (s_ready stays 0);
  - run begins.
- run_steps=5, STEP_DIV=4 -> 5 run strobes with prog=0, 4 cycles apart, then done=1. run_steps=0 -> DONE directly after pad with no run strobes.
- Mid-sequence checks:
  - start pulsed mid-load -> no effect.
  - rst_n=0 during L_PULSE -> advance and prog drop to 0 asynchronously the same cycle.
